// File: rtl/sysbus_rr_arbiter.sv
// N-client Sysbus request arbiter with a read-tag table that routes response bursts to their owner.
// Build option: define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module sysbus_rr_arbiter #(
  parameter int unsigned NCLIENT     = 2,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned TAG_WIDTH   = 13,
  parameter int unsigned WRITE_BEATS = 9,
  parameter int unsigned RESP_BEATS  = 8,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NCLIENT*DATA_WIDTH-1:0] c_req,
  input  logic [NCLIENT*TAG_WIDTH-1:0]  c_reqtag,
  input  logic [NCLIENT-1:0]            c_reqcyc,
  output logic [NCLIENT-1:0]            c_reqack,
  output logic [NCLIENT*DATA_WIDTH-1:0] c_resp,
  output logic [NCLIENT*TAG_WIDTH-1:0]  c_resptag,
  output logic [NCLIENT-1:0]            c_respcyc,
  input  logic [NCLIENT-1:0]            c_respack,
  output logic [DATA_WIDTH-1:0]         m_req,
  output logic [TAG_WIDTH-1:0]          m_reqtag,
  output logic                          m_reqcyc,
  input  logic                          m_reqack,
  input  logic [DATA_WIDTH-1:0]         m_resp,
  input  logic [TAG_WIDTH-1:0]          m_resptag,
  input  logic                          m_respcyc,
  output logic                          m_respack,
  output logic                          err_unmatched
);

  localparam int unsigned CW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam int unsigned BW = $clog2(WRITE_BEATS + 1);
  localparam int unsigned RW = $clog2(RESP_BEATS + 1);
  localparam int unsigned IW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   gnt_q, gnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            wr_q, wr_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  logic [OUTSTANDING-1:0] valid_q, valid_d;
  logic [TAG_WIDTH-1:0]   tag_q   [OUTSTANDING];
  logic [TAG_WIDTH-1:0]   tag_d   [OUTSTANDING];
  logic [CW-1:0]          owner_q [OUTSTANDING];
  logic [CW-1:0]          owner_d [OUTSTANDING];
  logic [RW-1:0]          rbeat_q [OUTSTANDING];
  logic [RW-1:0]          rbeat_d [OUTSTANDING];

  logic                  full;
  logic [NCLIENT-1:0]    dup;
  logic [NCLIENT-1:0]    elig;
  logic                  win_valid;
  logic [CW-1:0]         win;
  logic [DATA_WIDTH-1:0] gnt_req;
  logic [TAG_WIDTH-1:0]  gnt_tag;
  logic                  gnt_cyc;
  logic                  alloc;
  logic [IW-1:0]         free_idx;
  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic [CW-1:0]         hit_owner;
  logic                  resp_fire;

  // Full uses the registered valid bits, so a same-cycle free never unblocks a read.
  always_comb begin
    full = &valid_q;
    dup  = '0;
    elig = '0;
    for (int k = 0; k < NCLIENT; k++) begin
      for (int e = 0; e < OUTSTANDING; e++) begin
        if (valid_q[e] && (tag_q[e] == c_reqtag[k*TAG_WIDTH +: TAG_WIDTH])) begin
          dup[k] = 1'b1;
        end
      end
      elig[k] = c_reqcyc[k] &&
                (c_reqtag[k*TAG_WIDTH + (TAG_WIDTH-1)] || (!full && !dup[k]));
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    for (int i = NCLIENT - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_valid = 1'b1;
        win       = CW'(i);
      end
    end
  end
`else
  // Descending scan so the last hit is the first eligible client at or after rr_ptr.
  always_comb begin
    logic [CW-1:0] idx;
    win_valid = 1'b0;
    win       = '0;
    idx       = '0;
    for (int i = NCLIENT - 1; i >= 0; i--) begin
      idx = CW'((int'(rr_ptr_q) + i) % NCLIENT);
      if (elig[idx]) begin
        win_valid = 1'b1;
        win       = idx;
      end
    end
  end
`endif

  always_comb begin
    gnt_req = c_req[gnt_q*DATA_WIDTH +: DATA_WIDTH];
    gnt_tag = c_reqtag[gnt_q*TAG_WIDTH +: TAG_WIDTH];
    gnt_cyc = c_reqcyc[gnt_q];
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    beat_d   = beat_q;
    wr_d     = wr_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    m_req    = '0;
    m_reqtag = '0;
    m_reqcyc = 1'b0;
    c_reqack = '0;
    alloc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StGrant;
          gnt_d   = win;
          beat_d  = '0;
          wr_d    = c_reqtag[win*TAG_WIDTH + (TAG_WIDTH-1)];
        end
      end
      StGrant: begin
        m_req           = gnt_req;
        m_reqtag        = gnt_tag;
        m_reqcyc        = gnt_cyc;
        c_reqack[gnt_q] = m_reqack;
        if (m_reqack && gnt_cyc) begin
          beat_d = beat_q + 1'b1;
          if (!wr_q || (beat_q == BW'(WRITE_BEATS - 1))) begin
            state_d  = StIdle;
            alloc    = !wr_q;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_d = (gnt_q == CW'(NCLIENT - 1)) ? '0 : gnt_q + 1'b1;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      beat_q   <= '0;
      wr_q     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      beat_q   <= beat_d;
      wr_q     <= wr_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Tag lookup; duplicates are never admitted, so at most one entry matches.
  always_comb begin
    free_idx = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    for (int e = OUTSTANDING - 1; e >= 0; e--) begin
      if (!valid_q[e]) begin
        free_idx = IW'(e);
      end
      if (valid_q[e] && (tag_q[e] == m_resptag)) begin
        hit     = 1'b1;
        hit_idx = IW'(e);
      end
    end
    hit_owner = owner_q[hit_idx];
  end

  always_comb begin
    c_resp        = {NCLIENT{m_resp}};
    c_resptag     = {NCLIENT{m_resptag}};
    c_respcyc     = '0;
    m_respack     = 1'b0;
    err_unmatched = 1'b0;
    if (m_respcyc) begin
      if (hit) begin
        c_respcyc[hit_owner] = 1'b1;
        m_respack            = c_respack[hit_owner];
      end else begin
        m_respack     = 1'b1;
        err_unmatched = 1'b1;
      end
    end
    resp_fire = m_respcyc && hit && c_respack[hit_owner];
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    owner_d = owner_q;
    rbeat_d = rbeat_q;
    if (resp_fire) begin
      rbeat_d[hit_idx] = rbeat_q[hit_idx] + 1'b1;
      if (rbeat_q[hit_idx] == RW'(RESP_BEATS - 1)) begin
        valid_d[hit_idx] = 1'b0;
      end
    end
    // The free slot is invalid in valid_q, so it never collides with hit_idx.
    if (alloc) begin
      valid_d[free_idx] = 1'b1;
      tag_d[free_idx]   = gnt_tag;
      owner_d[free_idx] = gnt_q;
      rbeat_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int e = 0; e < OUTSTANDING; e++) begin
        tag_q[e]   <= '0;
        owner_q[e] <= '0;
        rbeat_q[e] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      owner_q <= owner_d;
      rbeat_q <= rbeat_d;
    end
  end

endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Self-checking bench for sysbus_rr_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model (tag map, per-client request queues).
module tb_sysbus_rr_arbiter;

  localparam int NC = 3;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int WB = 9;
  localparam int RB = 8;
  localparam int OS = 4;
  localparam int WBIT = 'h1000;

  logic             clk;
  logic             reset;
  logic [NC*DW-1:0] c_req;
  logic [NC*TW-1:0] c_reqtag;
  logic [NC-1:0]    c_reqcyc;
  logic [NC-1:0]    c_reqack;
  logic [NC*DW-1:0] c_resp;
  logic [NC*TW-1:0] c_resptag;
  logic [NC-1:0]    c_respcyc;
  logic [NC-1:0]    c_respack;
  logic [DW-1:0]    m_req;
  logic [TW-1:0]    m_reqtag;
  logic             m_reqcyc;
  logic             m_reqack;
  logic [DW-1:0]    m_resp;
  logic [TW-1:0]    m_resptag;
  logic             m_respcyc;
  logic             m_respack;
  logic             err_unmatched;

  sysbus_rr_arbiter #(
    .NCLIENT    (NC),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .WRITE_BEATS(WB),
    .RESP_BEATS (RB),
    .OUTSTANDING(OS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .c_req        (c_req),
    .c_reqtag     (c_reqtag),
    .c_reqcyc     (c_reqcyc),
    .c_reqack     (c_reqack),
    .c_resp       (c_resp),
    .c_resptag    (c_resptag),
    .c_respcyc    (c_respcyc),
    .c_respack    (c_respack),
    .m_req        (m_req),
    .m_reqtag     (m_reqtag),
    .m_reqcyc     (m_reqcyc),
    .m_reqack     (m_reqack),
    .m_resp       (m_resp),
    .m_resptag    (m_resptag),
    .m_respcyc    (m_respcyc),
    .m_respack    (m_respack),
    .err_unmatched(err_unmatched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: pending requests per client, outstanding reads keyed by tag, response bursts to send.
  int rq [NC][$];
  int owner_of [int];
  int beats_of [int];
  int resp_q [$];
  int mgnt = -1;
  int mbeat = 0;
  int mrr = 0;

  int ack_pct = 100;
  int rack_pct = 100;
  int auto_pct = 0;
  bit auto_resp = 0;
  logic [NC-1:0] rack_block = '0;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit is_write(input int tag);
    return (tag & WBIT) != 0;
  endfunction

  function automatic bit eligible(input int k);
    if (rq[k].size() == 0) return 1'b0;
    if (is_write(rq[k][0])) return 1'b1;
    return (owner_of.size() < OS) && !owner_of.exists(rq[k][0]);
  endfunction

  function automatic bit is_idle();
    bit quiet = (mgnt < 0) && (resp_q.size() == 0);
    for (int k = 0; k < NC; k++) if (rq[k].size() != 0) quiet = 1'b0;
    if (auto_resp && owner_of.size() != 0) quiet = 1'b0;
    return quiet;
  endfunction

  task automatic zero_inputs();
    c_req = '0; c_reqtag = '0; c_reqcyc = '0; c_respack = '0;
    m_reqack = 1'b0; m_resp = '0; m_resptag = '0; m_respcyc = 1'b0;
  endtask

  task automatic clear_model();
    mgnt = -1; mbeat = 0; mrr = 0;
    owner_of.delete(); beats_of.delete(); resp_q.delete();
    for (int k = 0; k < NC; k++) rq[k].delete();
    rack_block = '0;
  endtask

  // Hold reset for n cycles with whatever inputs are present, then check the post-reset state.
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
    zero_inputs();
    clear_model();
    #4;
    chk("rst_m_reqcyc", m_reqcyc, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_reqtag", m_reqtag, 0);
    chk("rst_c_reqack", c_reqack, 0);
    chk("rst_c_respcyc", c_respcyc, 0);
    chk("rst_m_respack", m_respack, 0);
    chk("rst_err_unmatched", err_unmatched, 0);
    chk("rst_c_resp", c_resp, 0);
    chk("rst_c_resptag", c_resptag, 0);
    @(posedge clk); #1;
  endtask

  task automatic cycle();
    int w;
    int tg;
    int own;
    logic [NC-1:0] exp_ack;
    logic [NC-1:0] exp_rcyc;
    logic exp_mrack;
    logic exp_err;
    if (auto_resp && resp_q.size() == 0 && owner_of.size() != 0 &&
        $urandom_range(99) < auto_pct) begin
      int key;
      int skip;
      void'(owner_of.first(key));
      skip = $urandom_range(owner_of.size() - 1);
      repeat (skip) void'(owner_of.next(key));
      resp_q.push_back(key);
    end
    for (int k = 0; k < NC; k++) begin
      c_reqcyc[k] = rq[k].size() != 0;
      c_reqtag[k*TW +: TW] = (rq[k].size() != 0) ? TW'(rq[k][0]) : '0;
      c_req[k*DW +: DW] = {$urandom, $urandom};
      c_respack[k] = !rack_block[k] && ($urandom_range(99) < rack_pct);
    end
    m_reqack = $urandom_range(99) < ack_pct;
    m_respcyc = resp_q.size() != 0;
    tg = m_respcyc ? resp_q[0] : -1;
    m_resptag = m_respcyc ? TW'(tg) : '0;
    m_resp = {$urandom, $urandom};
    #4;

    w = -1;
    if (mgnt < 0) begin
      chk("idle_m_reqcyc", m_reqcyc, 0);
      chk("idle_c_reqack", c_reqack, 0);
      for (int i = 0; i < NC && w < 0; i++) begin
        if (eligible((mrr + i) % NC)) w = (mrr + i) % NC;
      end
    end else begin
      chk("grant_m_reqcyc", m_reqcyc, c_reqcyc[mgnt]);
      chk("grant_m_reqtag", m_reqtag, rq[mgnt][0]);
      chk("grant_m_req", m_req, c_req[mgnt*DW +: DW]);
      exp_ack = '0;
      exp_ack[mgnt] = m_reqack;
      chk("grant_c_reqack", c_reqack, exp_ack);
    end

    exp_rcyc = '0;
    exp_mrack = 1'b0;
    exp_err = 1'b0;
    if (m_respcyc) begin
      if (owner_of.exists(tg)) begin
        own = owner_of[tg];
        exp_rcyc[own] = 1'b1;
        exp_mrack = c_respack[own];
        chk("resp_c_resp", c_resp, {NC{m_resp}});
        chk("resp_c_resptag", c_resptag, {NC{m_resptag}});
      end else begin
        exp_mrack = 1'b1;
        exp_err = 1'b1;
      end
    end
    chk("resp_c_respcyc", c_respcyc, exp_rcyc);
    chk("resp_m_respack", m_respack, exp_mrack);
    chk("resp_err_unmatched", err_unmatched, exp_err);

    if (m_respcyc && exp_mrack) begin
      if (owner_of.exists(tg)) begin
        beats_of[tg]++;
        if (beats_of[tg] == RB) begin
          owner_of.delete(tg);
          beats_of.delete(tg);
          void'(resp_q.pop_front());
        end
      end else begin
        void'(resp_q.pop_front());
      end
    end

    if (mgnt < 0) begin
      if (w >= 0) begin
        mgnt = w;
        mbeat = 0;
      end
    end else if (m_reqack && c_reqcyc[mgnt]) begin
      int rt = rq[mgnt][0];
      mbeat++;
      if (mbeat == (is_write(rt) ? WB : 1)) begin
        if (!is_write(rt)) begin
          owner_of[rt] = mgnt;
          beats_of[rt] = 0;
        end
        void'(rq[mgnt].pop_front());
        mrr = (mgnt + 1) % NC;
        mgnt = -1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (!is_idle() && n < budget) begin
      cycle();
      n++;
    end
    chk(name, is_idle(), 1);
  endtask

  initial begin
    reset = 1'b1;
    zero_inputs();
    do_reset(2);

    // Two simultaneous reads: client 0 first, then client 1 after one idle cycle.
    rq[0].push_back('h010);
    rq[1].push_back('h020);
    run_until_idle("two_reads_done", 40);

    // Out-of-order responses; owner 1 stalls for a few beats.
    resp_q.push_back('h020);
    resp_q.push_back('h010);
    rack_block[1] = 1'b1;
    run_cycles(4);
    rack_block = '0;
    run_until_idle("ooo_resp_done", 60);

    // Write burst on client 1 with a competing read on client 0.
    ack_pct = 70;
    rq[1].push_back('h1005);
    cycle();
    rq[0].push_back('h030);
    run_until_idle("write_then_read_done", 80);
    resp_q.push_back('h030);
    run_until_idle("write_test_resp_done", 40);

    // Fill the table, then a fifth read must wait for a free.
    ack_pct = 100;
    rq[0].push_back('h011);
    rq[1].push_back('h012);
    rq[2].push_back('h013);
    rq[0].push_back('h014);
    run_until_idle("fill_table_done", 60);
    rq[1].push_back('h015);
    run_cycles(10);
    resp_q.push_back('h012);
    run_until_idle("fifth_read_done", 60);
    resp_q.push_back('h011);
    resp_q.push_back('h013);
    resp_q.push_back('h014);
    resp_q.push_back('h015);
    run_until_idle("drain_four_done", 120);

    // Unknown tag and duplicate-tag blocking.
    resp_q.push_back('h07F);
    run_until_idle("unknown_tag_done", 10);
    rq[0].push_back('h040);
    run_until_idle("dup_first_done", 20);
    rq[1].push_back('h040);
    run_cycles(6);
    resp_q.push_back('h040);
    run_until_idle("dup_second_granted", 60);
    resp_q.push_back('h040);
    run_until_idle("dup_second_resp_done", 40);

    // Reset during beat 4 of a write, with a read left outstanding.
    rq[2].push_back('h022);
    run_until_idle("pre_reset_read_done", 20);
    rq[0].push_back('h1006);
    begin
      int n = 0;
      while (!(mgnt == 0 && mbeat == 3) && n < 40) begin
        cycle();
        n++;
      end
      chk("write_beat4_reached", mbeat, 3);
    end
    do_reset(1);
    resp_q.push_back('h022);
    run_until_idle("post_reset_table_empty", 10);
    rq[1].push_back('h021);
    run_until_idle("post_reset_read_done", 20);
    resp_q.push_back('h021);
    run_until_idle("post_reset_resp_done", 40);

    // Random traffic.
    ack_pct = 60;
    rack_pct = 70;
    auto_resp = 1'b1;
    auto_pct = 30;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) < 25) begin
        int k = $urandom_range(NC - 1);
        if (rq[k].size() < 2) begin
          if ($urandom_range(9) == 0) rq[k].push_back(WBIT | int'($urandom_range(255)));
          else rq[k].push_back('h050 + int'($urandom_range(5)));
        end
      end
      if (resp_q.size() == 0 && $urandom_range(99) < 2) resp_q.push_back('h07F);
      cycle();
    end
    auto_pct = 100;
    run_until_idle("random_drain_done", 4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysbus_rr_arbiter.md
# sysbus_rr_arbiter

Parametrised N-client arbiter between the cache-side requesters (instruction cache, data cache, and later prefetchers or a page walker) and the single Sysbus master port. It grants the request channel round-robin, holding each grant for a whole read or write burst. It records the tag of every outstanding read in a small tag table and routes each response burst back to the client that issued it. It replaces the fixed two-client icache/dcache arbiter.

## Interface
- NCLIENT, 2: number of requesting clients (≥2); client index width CW = $clog2(NCLIENT).
- DATA_WIDTH, 64: Sysbus data width.
- TAG_WIDTH, 13: Sysbus tag width; bit TAG_WIDTH-1 set = write request.
- WRITE_BEATS, 9: acked beats in one write burst (header + 8 data).
- RESP_BEATS, 8: beats in one read response burst.
- OUTSTANDING, 4: tag table depth (maximum reads in flight).

Ports:
- clk  in  1  bus clock.
- reset  in  1  synchronous, active-high.
- c_req  in  NCLIENT*DATA_WIDTH  per-client request data; client k occupies slice k.
- c_reqtag  in  NCLIENT*TAG_WIDTH  per-client request tag.
- c_reqcyc  in  NCLIENT  per-client request valid.
- c_reqack  out  NCLIENT  per-client request beat accepted.
- c_resp  out  NCLIENT*DATA_WIDTH  response data, broadcast to all slices.
- c_resptag  out  NCLIENT*TAG_WIDTH  response tag, broadcast to all slices.
- c_respcyc  out  NCLIENT  per-client response valid (one-hot or zero).
- c_respack  in  NCLIENT  per-client response beat consumed.
- m_req, m_reqtag, m_reqcyc  out  DATA_WIDTH / TAG_WIDTH / 1  Sysbus request.
- m_reqack  in  1  Sysbus request beat accepted.
- m_resp, m_resptag, m_respcyc  in  DATA_WIDTH / TAG_WIDTH / 1  Sysbus response.
- m_respack  out  1  Sysbus response beat consumed.
- err_unmatched  out  1  one-cycle pulse: response tag not in table.

## Operation
- Request FSM states: IDLE, GRANT.
- IDLE → GRANT:
  - Eligible client: c_reqcyc=1 and (write, or table not full).
  - Winner: first eligible client at or after rr_ptr, scanning upward with wrap. Latch gnt=winner and beat_cnt=0.
- GRANT:
  - m_req, m_reqtag and m_reqcyc come from client gnt.
  - c_reqack[gnt] = m_reqack; all other c_reqack bits are 0.
  - Each m_reqack increments beat_cnt.
- GRANT → IDLE: when the burst's last beat is acked (beat 1 for a read, beat WRITE_BEATS for a write).
  - On this transition: rr_ptr = (gnt+1) mod NCLIENT.
  - For a read: the tag and gnt are written into a free table entry (lowest free index).
- If client gnt drops c_reqcyc mid-burst (protocol violation): stay in GRANT, m_reqcyc follows it, and the burst does not complete.
- Response routing:
  - When m_respcyc=1, look up m_resptag among valid entries.
  - On a hit, drive c_respcyc[owner]=1 and set m_respack = c_respack[owner].
- Each acked response beat increments that entry's beat count. The entry is freed on the beat RESP_BEATS ack.
- Miss: m_respack=1, all c_respcyc=0, err_unmatched=1; the beat is dropped.
- Allocate and free in the same cycle are both honoured. Full is evaluated on the registered valid count, so a same-cycle free does not unblock eligibility.
- Duplicate tag already outstanding: that read is not eligible until the matching entry is freed.

## Timing
- Reset:
  - All outputs 0, FSM in IDLE, rr_ptr=0, all table entries invalid.
  - A reset mid-burst abandons the burst. m_reqcyc is 0 on the first cycle after reset.
- Grant latency: client reqcyc seen in IDLE at cycle t → m_reqcyc=1 at t+1.
- Back-to-back: the earliest next grant is the cycle after the IDLE return, so there is one idle bus cycle between bursts.
- Response path is combinational: m_respcyc/m_resptag → c_respcyc in the same cycle, and c_respack → m_respack in the same cycle.
- The request and response channels operate independently and concurrently.

## Configuration
- ARB_FIXED_PRIO_EN defined: the winner is the lowest-indexed eligible client; rr_ptr is not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Two clients both assert reads with tags 0x010 and 0x020 after reset → client 0 granted first, then client 1; m_reqcyc gap of exactly one cycle.
- Client 1 write with tag 0x1005 (MSB set) → 9 acked beats forwarded to c_reqack[1]; no table entry allocated; client 0 read waits until after beat 9.
- Four reads outstanding (OUTSTANDING=4), a fifth read asserted → not granted until one 8-beat response completes; granted the cycle after the free.
- Responses returned out of order (tag 0x020 before 0x010) → each burst appears only on its owner's c_respcyc; beats stall while that owner's c_respack=0.
- Response with unknown tag 0x07F → m_respack=1, err_unmatched pulses, no c_respcyc asserted.
- Reset asserted during beat 4 of a write → next cycle all outputs 0, table empty; new read from client 1 granted normally.
